// File: rtl/stream_sum_pkg.sv
// rtl/stream_sum_pkg.sv - shared constants and FSM encoding for stream_sum and its helpers
package stream_sum_pkg;

  localparam int INT_N = 8;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/stream_skid.sv
// rtl/stream_skid.sv - one-entry skid buffer for a valid/ready stream; empty path is combinational pass-through
module stream_skid
  import stream_sum_pkg::*;
#(
  parameter int N = INT_N
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic         full_q, full_d;
  logic [N-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      full_q <= FALSE;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (out_ready) full_d = FALSE;
    end else if (in_valid && !out_ready) begin
      full_d = TRUE;
      data_d = in_data;
    end
  end

  assign in_ready  = !full_q;
  assign out_valid = full_q || in_valid;
  assign out_data  = full_q ? data_q : in_data;

endmodule

// File: rtl/stream_sum.sv
// rtl/stream_sum.sv - reduces len stream elements to one sum; STREAM_SUM_SATURATE_EN selects saturating add plus ovf
module stream_sum
  import stream_sum_pkg::*;
#(
  parameter int N     = INT_N,
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN_W-1:0] len,
  input  logic [N-1:0]     sIn,
  input  logic             sIn_valid,
  output logic             sIn_ready,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef STREAM_SUM_SATURATE_EN
  output logic             ovf,
`endif
  output logic [ACC_W-1:0] sum
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               accept_en, start, fire, sk_in_ready, sk_valid;
  logic [N-1:0]       sk_data;

  assign accept_en = (state_q == ST_ACCUM);
  assign start     = in_valid && (state_q == ST_IDLE);
  assign fire      = sk_valid && accept_en;

  // The accumulator always drains the skid in ACCUM, so it only fills if that ever changes.
  stream_skid #(.N(N)) u_skid (
    .clk       (clk),
    .nrst      (nrst),
    .in_data   (sIn),
    .in_valid  (sIn_valid && accept_en),
    .in_ready  (sk_in_ready),
    .out_data  (sk_data),
    .out_valid (sk_valid),
    .out_ready (accept_en)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (len == '0) ? ST_EMIT : ST_ACCUM;
      ST_ACCUM: if (fire && rem_q == LEN_W'(1)) state_d = ST_EMIT;
      ST_EMIT:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_EMIT);
    sIn_ready = accept_en && sk_in_ready;
    sum       = acc_q;
  end

`ifdef STREAM_SUM_SATURATE_EN
  logic           ovf_q, ovf_d;
  logic [ACC_W:0] add_w;

  always_comb begin
    add_w = (ACC_W+1)'(acc_q) + (ACC_W+1)'(sk_data);
    acc_d = acc_q;
    rem_d = rem_q;
    ovf_d = ovf_q;
    if (start) begin
      acc_d = '0;
      rem_d = len;
      ovf_d = FALSE;
    end else if (fire) begin
      rem_d = rem_q - LEN_W'(1);
      if (add_w[ACC_W]) begin
        acc_d = '1;
        ovf_d = TRUE;
      end else begin
        acc_d = add_w[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) ovf_q <= FALSE;
    else       ovf_q <= ovf_d;
  end

  // Hidden while still reducing; held through IDLE until the next start clears it.
  assign ovf = ovf_q && (state_q != ST_ACCUM);
`else
  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    if (start) begin
      acc_d = '0;
      rem_d = len;
    end else if (fire) begin
      rem_d = rem_q - LEN_W'(1);
      acc_d = acc_q + ACC_W'(sk_data);
    end
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q <= '0;
      rem_q <= '0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: tb/tb_stream_sum.sv
// tb/tb_stream_sum.sv - directed and random checks of stream_sum at ACC_W=16 and ACC_W=8 against an arithmetic model
module tb_stream_sum;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid, out_ready, sIn_valid;
  logic [7:0]  len, sIn;
  logic        in_ready_w, sIn_ready_w, out_valid_w;
  logic        in_ready_n, sIn_ready_n, out_valid_n;
  logic [15:0] sum_w;
  logic [7:0]  sum_n;
`ifdef STREAM_SUM_SATURATE_EN
  logic        ovf_w, ovf_n;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] data_q[$];

  always #5 clk = ~clk;

  stream_sum #(.N(8), .ACC_W(16), .LEN_W(8)) u_wide (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready_w), .len(len),
    .sIn(sIn), .sIn_valid(sIn_valid), .sIn_ready(sIn_ready_w),
    .out_valid(out_valid_w), .out_ready(out_ready),
`ifdef STREAM_SUM_SATURATE_EN
    .ovf(ovf_w),
`endif
    .sum(sum_w)
  );

  stream_sum #(.N(8), .ACC_W(8), .LEN_W(8)) u_narrow (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready_n), .len(len),
    .sIn(sIn), .sIn_valid(sIn_valid), .sIn_ready(sIn_ready_n),
    .out_valid(out_valid_n), .out_ready(out_ready),
`ifdef STREAM_SUM_SATURATE_EN
    .ovf(ovf_n),
`endif
    .sum(sum_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input int unsigned total, input int w);
    int unsigned lim = (32'd1 << w) - 1;
`ifdef STREAM_SUM_SATURATE_EN
    return (total > lim) ? lim : total;
`else
    return total & lim;
`endif
  endfunction

  task automatic do_start(input logic [7:0] n);
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready_w}, 1);
    in_valid = 1'b1;
    len      = n;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("in_ready_after_start", {31'd0, in_ready_w}, 0);
  endtask

  task automatic run(input int hold, input bit bub, input bit early);
    int n = data_q.size();
    int idx = 0;
    int budget = 0;
    int extra = 0;
    int unsigned total = 0;
    bit phase = 1'b0;
    logic fire;
    out_ready = early;
    do_start(n[7:0]);
    while (idx < n && budget < 4 * n + 20) begin
      @(negedge clk);
      phase     = ~phase;
      sIn_valid = bub ? phase : 1'b1;
      sIn       = data_q[idx];
      #1 fire = sIn_valid && sIn_ready_w;
      @(posedge clk);
      if (fire) begin
        total += data_q[idx];
        idx++;
      end
      budget++;
    end
    check("accept_count", idx, n);
    @(negedge clk);
    sIn_valid = 1'b1;
    sIn       = 8'($urandom);
    #1;
    check("out_valid_latency", {31'd0, out_valid_w}, 1);
    check("out_valid_narrow", {31'd0, out_valid_n}, 1);
    check("excess_ready_low", {31'd0, sIn_ready_w}, 0);
    check("sum_wide", {16'd0, sum_w}, model(total, 16));
    check("sum_narrow", {24'd0, sum_n}, model(total, 8));
`ifdef STREAM_SUM_SATURATE_EN
    check("ovf_wide", {31'd0, ovf_w}, {31'd0, total > 32'd65535});
    check("ovf_narrow", {31'd0, ovf_n}, {31'd0, total > 32'd255});
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (sIn_ready_w) extra++;
      check("emit_hold_valid", {31'd0, out_valid_w}, 1);
      check("emit_hold_sum", {16'd0, sum_w}, model(total, 16));
    end
    check("no_excess_accept", extra, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    sIn_valid = 1'b0;
    check("out_valid_drop", {31'd0, out_valid_w}, 0);
    check("in_ready_back", {31'd0, in_ready_w}, 1);
  endtask

  initial begin
    nrst      = 1'b0;
    in_valid  = 1'b0;
    len       = '0;
    sIn       = '0;
    sIn_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready_w}, 1);
    check("rst_sIn_ready", {31'd0, sIn_ready_w}, 0);
    check("rst_out_valid", {31'd0, out_valid_w}, 0);
    check("rst_sum", {16'd0, sum_w}, 0);
    check("rst_narrow_ready", {30'd0, in_ready_n, sIn_ready_n}, 2);
    @(negedge clk);
    nrst = 1'b1;

    // Abandon a reduction after 3 of 5 elements.
    do_start(8'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sIn_valid = 1'b1;
      sIn       = 8'(50 + i);
      #1 check("mid_sIn_ready", {31'd0, sIn_ready_w}, 1);
    end
    @(negedge clk);
    sIn_valid = 1'b0;
    nrst      = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid_w}, 0);
    check("midrst_in_ready", {31'd0, in_ready_w}, 1);
    check("midrst_sum", {16'd0, sum_w}, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1 check("post_rst_in_ready", {31'd0, in_ready_w}, 1);
    data_q = '{8'd7, 8'd8};
    run(0, 1'b0, 1'b0);

    data_q = '{8'd0, 8'd1, 8'd2, 8'd3};
    run(0, 1'b0, 1'b1);

    data_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    run(1, 1'b0, 1'b0);

    data_q = '{8'd10, 8'd20, 8'd30};
    run(4, 1'b1, 1'b0);

    data_q.delete();
    run(0, 1'b0, 1'b0);

    data_q = '{8'd200, 8'd100};
    run(0, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      int n;
      data_q.delete();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
      run($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end

    data_q.delete();
    for (int i = 0; i < 255; i++) data_q.push_back(8'd255);
    run(0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
